// File: rtl/data_memory_pkg.sv
// Shared data-cache types and constants for the ways, the miss logic and the line refill sequencer.
// Packets carry one bank word plus the line's tag/valid/dirty status.
package data_memory_pkg;

  localparam int WAYS          = 4;
  localparam int WORDS         = 4;
  localparam int TAG_SIZE      = 20;
  localparam int INDEX_SIZE    = 8;
  localparam int WAY_SEL       = $clog2(WAYS);
  localparam int WORD_SEL      = $clog2(WORDS);
  localparam int MEM_ADDR_SIZE = TAG_SIZE + INDEX_SIZE + WORD_SEL;

  typedef struct packed {
    logic tag;
    logic valid;
    logic dirty;
    logic data;
  } data_cache_enable_t;

  typedef logic [WORD_SEL-1:0]   bank_select_t;
  typedef logic [3:0]            data_cache_byte_write_t;
  typedef logic [INDEX_SIZE-1:0] data_cache_index_t;

  typedef struct packed {
    logic [TAG_SIZE-1:0] tag;
    logic                valid;
    logic                dirty;
    logic [31:0]         data;
  } data_cache_packet_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    CHECK_WAIT,
    WB_READ,
    WB_WRITE,
    INVALIDATE,
    ALLOCATE,
    UPDATE
  } line_state_e;

endpackage

// File: rtl/data_cache_line_controller.sv
// Miss sequencer: inspect victim, write back if dirty, invalidate, refill word by word, install tag.
// Clean miss takes 4+WORDS cycles to done_o at zero-wait memory; memory requests are held until acknowledged.
module data_cache_line_controller
  import data_memory_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          miss_i,
  input  logic [TAG_SIZE+INDEX_SIZE-1:0] miss_address_i,
  input  logic [WAY_SEL-1:0]            victim_way_i,
  output logic                          ready_o,
  output logic                          done_o,
  output logic                          mem_read_o,
  output logic                          mem_write_o,
  output logic [MEM_ADDR_SIZE-1:0]      mem_address_o,
  output logic [31:0]                   mem_data_o,
  input  logic [31:0]                   mem_data_i,
  input  logic                          mem_valid_i,
  input  logic                          mem_write_done_i,
  output logic [WAYS-1:0]               enable_way_o,
  output logic                          port0_write_o,
  output data_cache_enable_t            port0_enable_o,
  output bank_select_t                  port0_bank_select_o,
  output data_cache_byte_write_t        port0_byte_write_o,
  output data_cache_index_t             port0_address_o,
  output data_cache_packet_t            port0_cache_packet_o,
  output logic                          port1_read_o,
  output data_cache_enable_t            port1_enable_o,
  output bank_select_t                  port1_bank_select_o,
  output data_cache_index_t             port1_address_o,
  input  data_cache_packet_t            port1_cache_packet_i
);

  localparam bank_select_t LAST_WORD = bank_select_t'(WORDS - 1);

  line_state_e         state_q;
  logic                ready_q, done_q, mem_read_q, mem_write_q;
  logic                port1_read_q, port0_write_q, wb_held_q;
  bank_select_t        count_q;
  logic [TAG_SIZE-1:0] tag_q, victim_tag_q;
  data_cache_index_t   index_q;
  logic [WAY_SEL-1:0]  victim_q;
  logic [31:0]         wb_data_q;
  logic                alloc_write;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      port1_read_q  <= 1'b0;
      port0_write_q <= 1'b0;
      wb_held_q     <= 1'b0;
      count_q       <= '0;
      tag_q         <= '0;
      victim_tag_q  <= '0;
      index_q       <= '0;
      victim_q      <= '0;
      wb_data_q     <= '0;
    end else begin
      done_q        <= 1'b0;
      port1_read_q  <= 1'b0;
      port0_write_q <= 1'b0;
      case (state_q)
        IDLE: if (miss_i) begin
          {tag_q, index_q} <= miss_address_i;
          victim_q         <= victim_way_i;
          count_q          <= '0;
          ready_q          <= 1'b0;
          port1_read_q     <= 1'b1;
          state_q          <= CHECK;
        end
        CHECK: state_q <= CHECK_WAIT;
        CHECK_WAIT: begin
          victim_tag_q <= port1_cache_packet_i.tag;
          if (port1_cache_packet_i.valid && port1_cache_packet_i.dirty) begin
            port1_read_q <= 1'b1;
            state_q      <= WB_READ;
          end else begin
            port0_write_q <= 1'b1;
            state_q       <= INVALIDATE;
          end
        end
        WB_READ: begin
          mem_write_q <= 1'b1;
          state_q     <= WB_WRITE;
        end
        WB_WRITE: begin
          // Port 1 data is only valid in the first cycle; keep it for stalled writes.
          if (!wb_held_q) begin
            wb_data_q <= port1_cache_packet_i.data;
            wb_held_q <= 1'b1;
          end
          if (mem_write_done_i) begin
            mem_write_q <= 1'b0;
            wb_held_q   <= 1'b0;
            if (count_q == LAST_WORD) begin
              count_q       <= '0;
              port0_write_q <= 1'b1;
              state_q       <= INVALIDATE;
            end else begin
              count_q      <= count_q + bank_select_t'(1);
              port1_read_q <= 1'b1;
              state_q      <= WB_READ;
            end
          end
        end
        INVALIDATE: begin
          mem_read_q <= 1'b1;
          state_q    <= ALLOCATE;
        end
        ALLOCATE: if (mem_valid_i) begin
          if (count_q == LAST_WORD) begin
            count_q       <= '0;
            mem_read_q    <= 1'b0;
            port0_write_q <= 1'b1;
            done_q        <= 1'b1;
            state_q       <= UPDATE;
          end else begin
            count_q <= count_q + bank_select_t'(1);
          end
        end
        UPDATE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Refill data is written in the same cycle memory returns it.
  assign alloc_write   = (state_q == ALLOCATE) && mem_valid_i;
  assign ready_o       = ready_q;
  assign done_o        = done_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_address_o = mem_write_q ? {victim_tag_q, index_q, count_q} :
                         mem_read_q  ? {tag_q, index_q, count_q} : '0;
  assign mem_data_o    = !mem_write_q ? '0 :
                         wb_held_q    ? wb_data_q : port1_cache_packet_i.data;

  assign port0_write_o   = port0_write_q | alloc_write;
  assign port0_address_o = port0_write_o ? index_q : '0;
  assign enable_way_o    = port0_write_o ? (WAYS'(1) << victim_q) : '0;

  always_comb begin
    port0_enable_o       = '0;
    port0_bank_select_o  = '0;
    port0_byte_write_o   = '0;
    port0_cache_packet_o = '0;
    if (alloc_write) begin
      port0_enable_o.data       = 1'b1;
      port0_bank_select_o       = count_q;
      port0_byte_write_o        = '1;
      port0_cache_packet_o.data = mem_data_i;
    end else if (port0_write_q) begin
      port0_enable_o.valid = 1'b1;
      port0_enable_o.dirty = 1'b1;
      if (state_q == UPDATE) begin
        port0_enable_o.tag         = 1'b1;
        port0_cache_packet_o.tag   = tag_q;
        port0_cache_packet_o.valid = 1'b1;
      end
    end
  end

  assign port1_read_o = port1_read_q;
  assign port1_address_o = port1_read_q ? index_q : '0;
  assign port1_bank_select_o = (port1_read_q && state_q == WB_READ) ? count_q : '0;

  always_comb begin
    port1_enable_o = '0;
    if (port1_read_q) begin
      if (state_q == WB_READ) begin
        port1_enable_o.data = 1'b1;
      end else begin
        port1_enable_o.tag   = 1'b1;
        port1_enable_o.valid = 1'b1;
        port1_enable_o.dirty = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_cache_line_controller.sv
// Directed bench: behavioural cache-way and memory models around the line controller, immediate-assert checks.
module tb_data_cache_line_controller;
  import data_memory_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n_i, miss_i;
  logic [27:0]            miss_address_i;
  logic [1:0]             victim_way_i;
  logic                   ready_o, done_o, mem_read_o, mem_write_o;
  logic [29:0]            mem_address_o;
  logic [31:0]            mem_data_o, mem_data_i;
  logic                   mem_valid_i, mem_write_done_i;
  logic [3:0]             enable_way_o;
  logic                   port0_write_o, port1_read_o;
  data_cache_enable_t     port0_enable_o, port1_enable_o;
  bank_select_t           port0_bank_select_o, port1_bank_select_o;
  data_cache_byte_write_t port0_byte_write_o;
  data_cache_index_t      port0_address_o, port1_address_o;
  data_cache_packet_t     port0_cache_packet_o, port1_cache_packet_i;

  data_cache_line_controller dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .miss_i(miss_i), .miss_address_i(miss_address_i),
    .victim_way_i(victim_way_i), .ready_o(ready_o), .done_o(done_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i),
    .mem_write_done_i(mem_write_done_i), .enable_way_o(enable_way_o),
    .port0_write_o(port0_write_o), .port0_enable_o(port0_enable_o),
    .port0_bank_select_o(port0_bank_select_o), .port0_byte_write_o(port0_byte_write_o),
    .port0_address_o(port0_address_o), .port0_cache_packet_o(port0_cache_packet_o),
    .port1_read_o(port1_read_o), .port1_enable_o(port1_enable_o),
    .port1_bank_select_o(port1_bank_select_o), .port1_address_o(port1_address_o),
    .port1_cache_packet_i(port1_cache_packet_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: read data = base + word offset, valid after stall_cfg waiting cycles; writes ack at once.
  logic [31:0] mem_base;
  int          stall_cfg, stall_cnt;
  always_comb begin
    mem_valid_i      = mem_read_o && (stall_cnt >= stall_cfg);
    mem_data_i       = mem_base + 32'(mem_address_o[1:0]);
    mem_write_done_i = mem_write_o;
  end
  always @(posedge clk) begin
    if (mem_read_o && !mem_valid_i) stall_cnt <= stall_cnt + 1;
    else                            stall_cnt <= 0;
  end

  // Cache ways model (single set); preload requests come from the stimulus block.
  logic [19:0] tag_m [4];
  logic        valid_m [4];
  logic        dirty_m [4];
  logic [31:0] data_m [4][4];
  logic        pre_vld;
  int          pre_way;
  logic [19:0] pre_tag;
  logic        pre_valid, pre_dirty;
  logic [31:0] pre_base;
  int          cur_way;

  always @(posedge clk) begin
    if (pre_vld) begin
      tag_m[pre_way]   <= pre_tag;
      valid_m[pre_way] <= pre_valid;
      dirty_m[pre_way] <= pre_dirty;
      for (int k = 0; k < 4; k++) data_m[pre_way][k] <= pre_base + 32'(k);
    end
    if (port0_write_o) begin
      for (int w = 0; w < 4; w++) if (enable_way_o[w]) begin
        if (port0_enable_o.tag)   tag_m[w]   <= port0_cache_packet_o.tag;
        if (port0_enable_o.valid) valid_m[w] <= port0_cache_packet_o.valid;
        if (port0_enable_o.dirty) dirty_m[w] <= port0_cache_packet_o.dirty;
        if (port0_enable_o.data && port0_byte_write_o == 4'hF)
          data_m[w][port0_bank_select_o] <= port0_cache_packet_o.data;
      end
    end
    if (port1_read_o)
      port1_cache_packet_i <= '{tag: tag_m[cur_way], valid: valid_m[cur_way], dirty: dirty_m[cur_way],
                                data: data_m[cur_way][port1_bank_select_o]};
  end

  // Monitors sampled mid-cycle.
  int          done_n = 0, p0_n = 0, dw_n = 0, wb_n = 0, way_err = 0, stab_err = 0, addr_err = 0;
  int          done_at [32];
  logic [29:0] wb_addr [16];
  logic [31:0] wb_dat [16];
  logic        pend_q = 1'b0;
  logic [29:0] pend_addr_q = '0;

  always @(negedge clk) begin
    if (done_o) begin
      done_at[done_n[4:0]] <= cyc;
      done_n <= done_n + 1;
    end
    if (port0_write_o) begin
      p0_n <= p0_n + 1;
      if (port0_enable_o.data) dw_n <= dw_n + 1;
      if (enable_way_o !== (4'b0001 << cur_way)) way_err <= way_err + 1;
      if (port0_address_o !== 8'h2A) addr_err <= addr_err + 1;
    end else if (enable_way_o !== 4'b0000) way_err <= way_err + 1;
    if (port1_read_o && port1_address_o !== 8'h2A) addr_err <= addr_err + 1;
    if (mem_write_o && mem_write_done_i) begin
      wb_addr[wb_n[3:0]] <= mem_address_o;
      wb_dat[wb_n[3:0]]  <= mem_data_o;
      wb_n <= wb_n + 1;
    end
    if (pend_q && (!mem_read_o || mem_address_o !== pend_addr_q)) stab_err <= stab_err + 1;
    pend_q      <= mem_read_o && !mem_valid_i;
    pend_addr_q <= mem_address_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int w, input logic [19:0] t, input logic v, input logic d, input logic [31:0] b);
    @(negedge clk);
    pre_way = w; pre_tag = t; pre_valid = v; pre_dirty = d; pre_base = b; pre_vld = 1'b1;
    @(posedge clk);
    #1 pre_vld = 1'b0;
  endtask

  int acc_cyc;
  task automatic launch(input logic [27:0] addr, input int w);
    @(negedge clk);
    chk("ready_before_miss", ready_o, 1);
    cur_way = w; miss_address_i = addr; victim_way_i = w[1:0]; miss_i = 1'b1; acc_cyc = cyc;
    @(posedge clk);
    #1 miss_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n0 = done_n;
    for (int i = 0; i < 300 && done_n == n0; i++) @(negedge clk);
    chk({tag, "_done_seen"}, 64'(done_n != n0), 1);
  endtask

  int b_p0, b_dw, b_wb, b_stab, b_done, d1;

  initial begin
    rst_n_i = 1'b0; miss_i = 1'b0; miss_address_i = '0; victim_way_i = '0;
    mem_base = '0; stall_cfg = 0; pre_vld = 1'b0; pre_way = 0; pre_tag = '0;
    pre_valid = 1'b0; pre_dirty = 1'b0; pre_base = '0; cur_way = 0;
    for (int w = 0; w < 4; w++) preload(w, 20'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_outputs_zero", 64'(|{done_o, mem_read_o, mem_write_o, mem_address_o, mem_data_o,
        enable_way_o, port0_write_o, port1_read_o, port0_enable_o, port1_enable_o}), 0);
    @(negedge clk) rst_n_i = 1'b1;

    // Clean miss, way 0
    b_p0 = p0_n; b_wb = wb_n; mem_base = 32'hA0;
    launch({20'h12345, 8'h2A}, 0);
    wait_done("clean");
    chk("clean_done_cycle", 64'(done_at[(done_n - 1) % 32] - acc_cyc), 8);
    chk("clean_no_writeback", 64'(wb_n - b_wb), 0);
    for (int k = 0; k < 4; k++) chk($sformatf("clean_word%0d", k), data_m[0][k], 32'hA0 + 32'(k));
    chk("clean_tag", tag_m[0], 20'h12345);
    chk("clean_valid_dirty", {valid_m[0], dirty_m[0]}, 2'b10);
    chk("clean_port0_writes", 64'(p0_n - b_p0), 6);
    @(negedge clk);
    chk("clean_ready_back", ready_o, 1);

    // Dirty miss, way 1
    preload(1, 20'h00077, 1'b1, 1'b1, 32'hD0);
    b_wb = wb_n; mem_base = 32'hB0;
    launch({20'h54321, 8'h2A}, 1);
    wait_done("dirty");
    chk("dirty_done_cycle", 64'(done_at[(done_n - 1) % 32] - acc_cyc), 16);
    chk("dirty_wb_count", 64'(wb_n - b_wb), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dirty_wb_addr%0d", k), wb_addr[(b_wb + k) % 16], {20'h00077, 8'h2A, 2'(k)});
      chk($sformatf("dirty_wb_data%0d", k), wb_dat[(b_wb + k) % 16], 32'hD0 + 32'(k));
    end
    chk("dirty_refill_word3", data_m[1][3], 32'hB3);
    chk("dirty_line_status", {tag_m[1], valid_m[1], dirty_m[1]}, {20'h54321, 2'b10});

    // Memory stalls, way 0
    b_stab = stab_err; b_dw = dw_n; mem_base = 32'hC0; stall_cfg = 3;
    launch({20'h0BEEF, 8'h2A}, 0);
    wait_done("stall");
    chk("stall_done_cycle", 64'(done_at[(done_n - 1) % 32] - acc_cyc), 20);
    chk("stall_read_stable", 64'(stab_err - b_stab), 0);
    chk("stall_one_write_per_word", 64'(dw_n - b_dw), 4);
    chk("stall_word0", data_m[0][0], 32'hC0);
    chk("stall_word3", data_m[0][3], 32'hC3);
    stall_cfg = 0;

    // Requests while busy: short pulse ignored, held request taken when ready returns
    b_done = done_n; mem_base = 32'h50;
    launch({20'h0AAAA, 8'h2A}, 0);
    for (int i = 0; i < 50 && !mem_read_o; i++) @(negedge clk);
    chk("busy_in_allocate", mem_read_o, 1);
    miss_address_i = {20'h0DEAD, 8'h2A}; miss_i = 1'b1;
    @(negedge clk) miss_i = 1'b0;
    @(negedge clk) begin miss_address_i = {20'h0BBBB, 8'h2A}; miss_i = 1'b1; end
    wait_done("busy_first");
    d1 = done_at[(done_n - 1) % 32];
    chk("busy_first_tag", tag_m[0], 20'h0AAAA);
    chk("busy_ready_after_done", ready_o, 1);
    chk("busy_ready_cycle", 64'(cyc - d1), 1);
    @(posedge clk);
    #1 miss_i = 1'b0;
    wait_done("busy_second");
    chk("busy_second_done_cycle", 64'(done_at[(done_n - 1) % 32] - d1), 9);
    chk("busy_second_tag", tag_m[0], 20'h0BBBB);
    repeat (12) @(negedge clk);
    chk("busy_done_count", 64'(done_n - b_done), 2);

    // Reset while refilling word 2 of way 1
    mem_base = 32'hE0;
    launch({20'h0CAFE, 8'h2A}, 1);
    for (int i = 0; i < 50 && !(mem_read_o && mem_address_o[1:0] == 2'd2); i++) @(negedge clk);
    chk("rst_reached_word2", {mem_read_o, mem_address_o[1:0]}, 3'b110);
    rst_n_i = 1'b0;
    #1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_outputs_zero", 64'(|{done_o, mem_read_o, mem_write_o, mem_address_o,
        enable_way_o, port0_write_o, port1_read_o}), 0);
    chk("midrst_line_invalid", valid_m[1], 0);
    chk("midrst_word1_refilled", data_m[1][1], 32'hE1);
    chk("midrst_word2_untouched", data_m[1][2], 32'hB2);
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
    launch({20'h0CAFE, 8'h2A}, 1);
    wait_done("after_rst");
    chk("after_rst_done_cycle", 64'(done_at[(done_n - 1) % 32] - acc_cyc), 8);
    chk("after_rst_line", {tag_m[1], valid_m[1], dirty_m[1], data_m[1][2]}, {20'h0CAFE, 2'b10, 32'hE2});

    // Victim way 3
    preload(3, 20'h0, 1'b0, 1'b0, 32'h0);
    b_p0 = p0_n; mem_base = 32'hF0;
    launch({20'h0F00D, 8'h2A}, 3);
    wait_done("way3");
    chk("way3_port0_writes", 64'(p0_n - b_p0), 6);
    chk("way3_tag", {tag_m[3], valid_m[3]}, {20'h0F00D, 1'b1});
    chk("way3_word1", data_m[3][1], 32'hF1);
    chk("other_way_untouched", tag_m[2], 20'h0);
    @(negedge clk);
    chk("way_enable_errors", 64'(way_err), 0);
    chk("port_index_errors", 64'(addr_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
